freq_meter: RTL

Measures the frequency of a toggling input, typically syn_clk from the frequency synthesizer, against ref_clk. It counts rising edges of the input over a programmable gate window of ref_clk cycles. The result, edge count plus overflow flag, is delivered on a valid/ready handshake. It is the feedback/readback end of the synthesizer path: the gate count, scaled by f_ref, gives the achieved output frequency for calibration of ctrl.

---
 rtl/freq_meter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous input over a gate_len-cycle
// window of ref_clk and returns the count on a valid/ready handshake. Optional: FREQ_METER_DEGLITCH_EN.
module freq_meter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              ref_clk,
  input  logic              rst,
  input  logic              syn_in,
  input  logic              start,
  input  logic              continuous,
  input  logic [GATE_W-1:0] gate_len,
  output logic [CNT_W-1:0]  meas_count,
  output logic              meas_overflow,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

  localparam logic [GATE_W-1:0] WIN_LAST = GATE_W'(1);

  state_t             state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               s_sync, s_prev, level, edge_pulse;
  logic [GATE_W-1:0]  win_cnt;
  logic [CNT_W-1:0]   edge_cnt, cnt_next;
  logic               ovf, ovf_next;
  logic               handshake, last_cycle, arm, gate_ok;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge ref_clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], syn_in};
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef FREQ_METER_DEGLITCH_EN
  // Level follows s_sync only once it has been stable for two consecutive cycles.
  logic s_hold, filt_q;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      s_hold <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      s_hold <= s_sync;
      filt_q <= level;
    end
  end

  assign level = (s_sync == s_hold) ? s_sync : filt_q;
`else
  assign level = s_sync;
`endif

  always_ff @(posedge ref_clk) begin
    if (rst) s_prev <= 1'b0;
    else     s_prev <= level;
  end

  assign edge_pulse = level & ~s_prev;

  assign gate_ok    = (gate_len != '0);
  assign handshake  = meas_valid & meas_ready;
  assign last_cycle = (state == MEASURE) && (win_cnt == WIN_LAST);

  // FSM: state register
  always_ff @(posedge ref_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && gate_ok) state_next = MEASURE;
      MEASURE: if (last_cycle)       state_next = REPORT;
      REPORT:  if (handshake)        state_next = (continuous && gate_ok) ? MEASURE : IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    meas_valid = (state == REPORT);
  end

  // A new window is armed from IDLE on start, or from REPORT on a continuous handshake.
  assign arm = (state_next == MEASURE) && (state != MEASURE);

  always_comb begin
    cnt_next = edge_cnt;
    ovf_next = ovf;
    if (edge_pulse) begin
      if (&edge_cnt) ovf_next = 1'b1;
      else           cnt_next = edge_cnt + 1'b1;
    end
  end

  // NOTE: the result registers are reset too, since they are visible outputs held across IDLE.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      win_cnt       <= '0;
      edge_cnt      <= '0;
      ovf           <= 1'b0;
      meas_count    <= '0;
      meas_overflow <= 1'b0;
    end else if (arm) begin
      win_cnt  <= gate_len;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else if (state == MEASURE) begin
      win_cnt  <= win_cnt - 1'b1;
      edge_cnt <= cnt_next;
      ovf      <= ovf_next;
      if (last_cycle) begin
        meas_count    <= cnt_next;
        meas_overflow <= ovf_next;
      end
    end
  end

endmodule
